spi_bist_responder: RTL and testbench
=====================================

// Module: spi_bist_responder
// PURPOSE
//   SPI mode-0 slave that answers the BIST SPI master. Receives DATA_W-bit MOSI frames and returns
//   a preloaded response on MISO. SCLK/CS_N/MOSI are synchronised into clk, so clk >= 4x SCLK.
//   Sits on the far side of the BIST SPI link.
//   The optional MISR compacts every received bit into a 4-bit signature for pass/fail comparison.
// PARAMETERS
//   DATA_W  8      frame width in bits, MSB first
//   FILL    8'hFF  byte shifted out on MISO when no response is buffered (width DATA_W)
// PORTS
//   clk         in   1       system clock, rising edge
//   reset       in   1       asynchronous, active-low reset
//   sclk        in   1       SPI clock from master (async to clk)
//   cs_n        in   1       SPI chip select, active low (async)
//   mosi        in   1       SPI data master->slave (async)
//   miso        out  1       SPI data slave->master
//   tx_data     in   DATA_W  response word to send
//   tx_load     in   1       write tx_data into response buffer; accepted only when tx_ready=1
//   tx_ready    out  1       response buffer empty
//   tx_underrun out  1       1-cycle pulse: frame started with empty buffer, FILL sent
//   rx_data     out  DATA_W  last complete received frame; held until next completion
//   rx_valid    out  1       1-cycle pulse: rx_data updated
//   busy        out  1       1 while cs_n (synchronised) is low
//   signature   out  4       MISR signature (see CONFIGURATION)
// BEHAVIOUR
//   Reset (reset=0):
//     miso=0, tx_ready=1, tx_underrun=0, rx_data=0, rx_valid=0, busy=0, signature=0.
//     Bit counter=0; FSM=IDLE; buffer empty.
//   Sync: 2-FF synchroniser on sclk, cs_n, mosi, then edge detect on the synced copies.
//     Latency from pin edge to internal action is 3 clk.
//   FSM:
//     IDLE -> LOAD on cs_n fall.
//     LOAD (1 cycle) -> SHIFT.
//       Shift reg <= buffer if full (buffer freed, tx_ready=1 next cycle),
//       else FILL with a tx_underrun pulse. miso = shift-reg MSB.
//     SHIFT: sclk rise samples mosi into rx shift reg, bit_cnt+1.
//       sclk fall shifts the tx reg left and miso = new MSB.
//     On the DATA_W-th rise: rx_data <= assembled word, rx_valid pulse, bit_cnt=0.
//       Next frame reload (as LOAD) happens on the following sclk fall.
//       Continuous frames are allowed while cs_n stays low.
//     cs_n rise in any state -> IDLE.
//       Partial frame discarded: no rx_valid, bit_cnt=0, miso=0 next cycle, buffer untouched.
//   tx handshake: a tx_load with tx_ready=0 is ignored.
//     If tx_load coincides with a LOAD, LOAD sees the old state (no bypass).
//     An empty buffer sends FILL and the new word is kept for the next frame.
//   cs_n rise and sclk rise in the same synced cycle: the cs_n rise wins, that bit is not counted.
//   Reset asserted mid-frame: immediate return to reset values; the frame is lost.
// CONFIGURATION
//   SPI_MISR_EN defined:
//     On every counted sclk-rise sample b, with f = sig[3]:
//       sig <= {sig[2], sig[1], sig[0]^f, f^b}   (poly x^4+x+1).
//     Bits of aborted frames are included. Cleared only by reset.
//   SPI_MISR_EN undefined: no MISR logic; signature tied to 4'h0.
// TESTING
//   1 Reset:
//     Hold reset=0 mid-activity -> miso=0, tx_ready=1, rx_valid=0, busy=0, signature=0.
//   2 Basic frame:
//     tx_load 8'h3C, then master (SCLK=clk/8) sends 8'hA5.
//     -> miso bits 0,0,1,1,1,1,0,0; one rx_valid with rx_data=8'hA5; tx_ready re-asserts at LOAD.
//   3 Underrun:
//     Frame with no tx_load -> miso=8'hFF bits, one tx_underrun pulse, rx_data=mosi word.
//   4 Abort:
//     cs_n high after 5 bits -> no rx_valid, rx_data unchanged.
//     A following full frame 8'h5A -> rx_data=8'h5A.
//   5 Back-to-back:
//     2 frames in one cs_n low; tx_load 8'h81 during frame 1.
//     -> two rx_valid pulses; miso frame 2 = 8'h81.
//   6 MISR:
//     After reset, one frame 8'hA5 -> signature=4'b1000 with SPI_MISR_EN; 4'b0000 without.

Source files
------------

// File: rtl/spi_bist_responder_if.sv
// Bus bundle for spi_bist_responder: SPI pins plus the local tx/rx handshake and MISR signature.
interface spi_bist_responder_if #(
  parameter int unsigned DATA_W = 8
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;
  logic              tx_underrun;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic [3:0]        signature;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_load,
    output miso, tx_ready, tx_underrun, rx_data, rx_valid, busy, signature
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_load,
    input  miso, tx_ready, tx_underrun, rx_data, rx_valid, busy, signature
  );
endinterface

// File: rtl/spi_bist_responder.sv
// SPI mode-0 slave for the BIST link: oversampled SCLK/CS_N/MOSI, one-deep response buffer.
// Optional 4-bit MISR over received bits is enabled by defining SPI_MISR_EN.
module spi_bist_responder #(
  parameter int unsigned       DATA_W = 8,
  parameter logic [DATA_W-1:0] FILL   = DATA_W'(8'hFF)
) (
  input logic                  clk,
  input logic                  reset,
  spi_bist_responder_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  logic [2:0]        sclk_sync_q, sclk_sync_d;
  logic [2:0]        cs_sync_q, cs_sync_d;
  logic [1:0]        mosi_sync_q, mosi_sync_d;
  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              full_q, full_d;
  logic              reload_q, reload_d;
  logic              do_load;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];

`ifdef SPI_MISR_EN
  logic [3:0] sig_q, sig_d;
  assign bus.signature = sig_q;
`else
  assign bus.signature = 4'h0;
`endif

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], bus.sclk};
    cs_sync_d   = {cs_sync_q[1:0], bus.cs_n};
    mosi_sync_d = {mosi_sync_q[0], bus.mosi};
    state_d     = state_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    bit_cnt_d   = bit_cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    buf_d       = buf_q;
    full_d      = full_q;
    reload_d    = reload_q;
    do_load     = 1'b0;
`ifdef SPI_MISR_EN
    sig_d       = sig_q;
`endif

    if (bus.tx_load && !full_q) begin
      full_d = 1'b1;
      buf_d  = bus.tx_data;
    end

    case (state_q)
      LOAD: begin
        if (cs_rise) begin
          state_d = IDLE;
        end else begin
          do_load   = 1'b1;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // cs_n rise outranks a same-cycle sclk rise: the bit is dropped
        if (cs_rise) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          reload_d  = 1'b0;
        end else if (sclk_rise) begin
          rx_sr_d = {rx_sr_q[DATA_W-2:0], mosi_s};
`ifdef SPI_MISR_EN
          sig_d = {sig_q[2:0], mosi_s} ^ {2'b00, sig_q[3], sig_q[3]};
`endif
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = rx_sr_d;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            reload_d   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          if (reload_q) begin
            do_load  = 1'b1;
            reload_d = 1'b0;
          end else begin
            tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      default: begin
        bit_cnt_d = '0;
        reload_d  = 1'b0;
        if (cs_fall) state_d = LOAD;
      end
    endcase

    // Consumption only occurs with the buffer full, so it never races an accepted tx_load
    if (do_load) begin
      if (full_q) begin
        tx_sr_d = buf_q;
        full_d  = 1'b0;
      end else begin
        tx_sr_d    = FILL;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      buf_q       <= '0;
      full_q      <= 1'b0;
      reload_q    <= 1'b0;
`ifdef SPI_MISR_EN
      sig_q       <= '0;
`endif
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      buf_q       <= buf_d;
      full_q      <= full_d;
      reload_q    <= reload_d;
`ifdef SPI_MISR_EN
      sig_q       <= sig_d;
`endif
    end
  end

  assign bus.miso        = (state_q == SHIFT) & tx_sr_q[DATA_W-1];
  assign bus.tx_ready    = ~full_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.busy        = ~cs_sync_q[1];
endmodule

// File: tb/tb_spi_bist_responder.sv
// Self-checking bench for spi_bist_responder: a behavioural SPI master plus a frame-level model
// of the response buffer and MISR, driven by a vector table, corner sequences and random bursts.
module tb_spi_bist_responder;
  localparam int END_FINAL   = 0;
  localparam int END_CONT    = 1;
  localparam int END_COLLIDE = 2;
`ifdef SPI_MISR_EN
  localparam bit MISR_ON = 1'b1;
`else
  localparam bit MISR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  spi_bist_responder_if #(.DATA_W(8)) bus ();
  spi_bist_responder #(.DATA_W(8), .FILL(8'hFF)) dut (.clk(clk), .reset(reset_n), .bus(bus));

  int passed = 0;
  int total  = 0;
  int rx_pulses = 0;
  int und_pulses = 0;

  // Frame-level reference: one-deep buffer and MISR signature as polynomial arithmetic
  bit         m_full = 1'b0;
  logic [7:0] m_buf  = '0;
  logic [3:0] m_sig  = '0;

  always @(negedge clk) begin
    if (bus.rx_valid)    rx_pulses++;
    if (bus.tx_underrun) und_pulses++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, required finish before limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic logic [3:0] misr_step(input logic [3:0] s, input logic b);
    logic [4:0] t;
    t = {s, b};
    if (t[4]) t = t ^ 5'b10011;
    return t[3:0];
  endfunction

  function automatic logic [3:0] exp_sig();
    return MISR_ON ? m_sig : 4'h0;
  endfunction

  task automatic model_take(output logic [7:0] resp, output int und);
    if (m_full) begin
      resp = m_buf; m_full = 1'b0; und = 0;
    end else begin
      resp = 8'hFF; und = 1;
    end
  endtask

  task automatic load_word(input logic [7:0] w);
    check("tx_ready_before_load", {31'd0, bus.tx_ready}, {31'd0, !m_full});
    bus.tx_data = w;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
    if (!m_full) begin
      m_full = 1'b1; m_buf = w;
    end
  endtask

  task automatic xfer(input logic [7:0] w, input int nbits, input int endmode, output logic [7:0] got);
    got = '0;
    for (int k = 0; k < nbits; k++) begin
      bus.mosi = w[7-k];
      repeat (4) @(negedge clk);
      got[7-k] = bus.miso;
      bus.sclk = 1'b1;
      m_sig = misr_step(m_sig, w[7-k]);
      repeat (4) @(negedge clk);
      if (k < nbits - 1 || endmode == END_CONT) bus.sclk = 1'b0;
    end
    if (endmode == END_FINAL) begin
      bus.cs_n = 1'b1;
      repeat (4) @(negedge clk);
      bus.sclk = 1'b0;
      repeat (8) @(negedge clk);
    end else if (endmode == END_COLLIDE) begin
      bus.sclk = 1'b0;
      bus.mosi = w[7-nbits];
      repeat (4) @(negedge clk);
      bus.sclk = 1'b1;
      bus.cs_n = 1'b1;
      repeat (4) @(negedge clk);
      bus.sclk = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic run_burst(input int n, input logic [7:0] mw [4], input bit pre, input logic [7:0] pw,
                           input bit mid [4], input logic [7:0] midw [4],
                           output logic [7:0] last_got, output int und_exp);
    int rx0, un0, u;
    logic [7:0] resp, got;
    und_exp = 0;
    last_got = '0;
    if (pre) load_word(pw);
    rx0 = rx_pulses; un0 = und_pulses;
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int f = 0; f < n; f++) begin
      model_take(resp, u);
      und_exp += u;
      fork
        xfer(mw[f], 8, (f == n - 1) ? END_FINAL : END_CONT, got);
        if (mid[f]) begin
          repeat (20) @(negedge clk);
          load_word(midw[f]);
        end
      join
      check("miso_word", {24'd0, got}, {24'd0, resp});
      check("rx_data", {24'd0, bus.rx_data}, {24'd0, mw[f]});
      last_got = got;
    end
    check("rx_valid_count", rx_pulses - rx0, n);
    check("underrun_count", und_pulses - un0, und_exp);
    check("tx_ready_after", {31'd0, bus.tx_ready}, {31'd0, !m_full});
    check("signature", {28'd0, bus.signature}, {28'd0, exp_sig()});
  endtask

  typedef struct {
    bit         do_load;
    logic [7:0] load;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    int         exp_und;
  } vec_t;

  vec_t tbl [5];
  logic [7:0] mw [4];
  logic [7:0] midw [4];
  bit mid [4];
  logic [7:0] got, resp, rx_prev;
  int u, rx0;

  initial begin
    tbl[0] = '{1'b1, 8'h3C, 8'hA5, 8'h3C, 0};
    tbl[1] = '{1'b0, 8'h00, 8'hC3, 8'hFF, 1};
    tbl[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 0};
    tbl[3] = '{1'b1, 8'h81, 8'h00, 8'h81, 0};
    tbl[4] = '{1'b0, 8'h00, 8'h5A, 8'hFF, 1};
    for (int i = 0; i < 4; i++) begin mw[i] = '0; midw[i] = '0; mid[i] = 1'b0; end

    bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
    bus.tx_data = '0; bus.tx_load = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", {31'd0, bus.miso}, 0);
    check("rst_tx_ready", {31'd0, bus.tx_ready}, 1);
    check("rst_underrun", {31'd0, bus.tx_underrun}, 0);
    check("rst_rx_data", {24'd0, bus.rx_data}, 0);
    check("rst_rx_valid", {31'd0, bus.rx_valid}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_signature", {28'd0, bus.signature}, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      mw[0] = tbl[i].mosi;
      run_burst(1, mw, tbl[i].do_load, tbl[i].load, mid, midw, got, u);
      check("tbl_miso", {24'd0, got}, {24'd0, tbl[i].exp_miso});
      check("tbl_underrun", u, tbl[i].exp_und);
      if (i == 0) check("misr_after_a5", {28'd0, bus.signature}, MISR_ON ? 32'h8 : 32'h0);
    end

    // Second load while full is ignored
    load_word(8'h11);
    mw[0] = 8'h3E;
    run_burst(1, mw, 1'b1, 8'h22, mid, midw, got, u);
    check("ignored_load_miso", {24'd0, got}, 32'h11);

    // Abort after 5 bits, then a full frame
    rx_prev = bus.rx_data; rx0 = rx_pulses;
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    model_take(resp, u);
    xfer(8'hE7, 5, END_FINAL, got);
    check("abort_rx_valid", rx_pulses - rx0, 0);
    check("abort_rx_data", {24'd0, bus.rx_data}, {24'd0, rx_prev});
    check("abort_busy", {31'd0, bus.busy}, 0);
    mw[0] = 8'h5A;
    run_burst(1, mw, 1'b0, 8'h00, mid, midw, got, u);

    // Back-to-back: word loaded during frame 1 is sent in frame 2
    mw[0] = 8'h12; mw[1] = 8'h34; mid[0] = 1'b1; midw[0] = 8'h81;
    run_burst(2, mw, 1'b0, 8'h00, mid, midw, got, u);
    check("b2b_frame2_miso", {24'd0, got}, 32'h81);
    mid[0] = 1'b0;

    // cs_n rise collides with the 8th sclk rise: bit not counted, no frame
    rx_prev = bus.rx_data; rx0 = rx_pulses;
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    model_take(resp, u);
    xfer(8'hC3, 7, END_COLLIDE, got);
    check("collide_rx_valid", rx_pulses - rx0, 0);
    check("collide_rx_data", {24'd0, bus.rx_data}, {24'd0, rx_prev});
    check("collide_signature", {28'd0, bus.signature}, {28'd0, exp_sig()});
    mw[0] = 8'h96;
    run_burst(1, mw, 1'b0, 8'h00, mid, midw, got, u);

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 4; i++) begin
        mw[i] = 8'($urandom); midw[i] = 8'($urandom); mid[i] = 1'($urandom);
      end
      run_burst(int'($urandom_range(1, 3)), mw, 1'($urandom), 8'($urandom), mid, midw, got, u);
    end

    // Reset asserted mid-frame with a word buffered
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    model_take(resp, u);
    xfer(8'hF0, 3, END_CONT, got);
    if (!m_full) load_word(8'h77);
    reset_n = 1'b0;
    #1;
    check("midrst_miso", {31'd0, bus.miso}, 0);
    check("midrst_tx_ready", {31'd0, bus.tx_ready}, 1);
    check("midrst_rx_valid", {31'd0, bus.rx_valid}, 0);
    check("midrst_rx_data", {24'd0, bus.rx_data}, 0);
    check("midrst_busy", {31'd0, bus.busy}, 0);
    check("midrst_signature", {28'd0, bus.signature}, 0);
    m_full = 1'b0; m_sig = '0;
    @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    mw[0] = 8'hA5;
    run_burst(1, mw, 1'b0, 8'h00, mid, midw, got, u);
    check("post_reset_misr", {28'd0, bus.signature}, MISR_ON ? 32'h8 : 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
